// File: rtl/usb_fifo_pkg.sv
// Shared helpers and defaults for the USB IN/OUT endpoint FIFOs.
// Pointers wrap at an arbitrary buffer length, so they are not power-of-two masks.
package usb_fifo_pkg;

  localparam int MAXPACKETSIZE_DEFAULT = 8;
  localparam int BUFFER_LENGTH_DEFAULT = 16;

  function automatic int ceil_log2(input int unsigned value);
    int result;
    result = 1;
    for (int i = 1; i < 32; i++) begin
      if ((32'd1 << (i - 1)) < value) begin
        result = i;
      end
    end
    return result;
  endfunction

  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned len);
    return (ptr == len - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

  // Distance from first to last going forward around a ring of len slots.
  function automatic int unsigned ptr_dist(input int unsigned last, input int unsigned first,
                                           input int unsigned len);
    return (last >= first) ? (last - first) : (last + len - first);
  endfunction

endpackage

// File: rtl/out_fifo_sc.sv
// USB full-speed OUT endpoint FIFO: speculative packet writes from the SIE,
// commit or rollback at end of packet, committed bytes drained by the app.
module out_fifo_sc
  import usb_fifo_pkg::*;
#(
  parameter int OUT_MAXPACKETSIZE = MAXPACKETSIZE_DEFAULT,
  parameter int OUT_BUFFER_LENGTH = BUFFER_LENGTH_DEFAULT
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       clk_gate_i,
  input  logic [7:0] out_data_i,
  input  logic       out_valid_i,
  input  logic       out_ready_i,
  input  logic       out_err_i,
  output logic       out_full_o,
  output logic       out_empty_o,
  output logic [7:0] app_out_data_o,
  output logic       app_out_valid_o,
  input  logic       app_out_ready_i
);

  localparam int PTR_W = ceil_log2(OUT_BUFFER_LENGTH);

  logic [PTR_W-1:0] first_q;
  logic [PTR_W-1:0] last_q;
  logic [PTR_W-1:0] last_qq;
  logic             ovf_q;
  logic [7:0]       storage_q [OUT_BUFFER_LENGTH];

  logic [PTR_W-1:0] first_inc_s;
  logic [PTR_W-1:0] last_qq_inc_s;
  logic [PTR_W-1:0] spec_end_s;
  logic [PTR_W-1:0] first_d_s;
  logic [PTR_W-1:0] last_d_s;
  logic [PTR_W-1:0] last_qq_d_s;
  logic             wr_s;
  logic             drop_s;
  logic             eop_s;
  logic             pop_s;
  logic             ovf_d_s;
  logic             full_d_s;
  int unsigned      used_s;

  // Next-state pointers; full is judged on post-update pointers so a pop counts at once.
  always_comb begin
    first_inc_s   = PTR_W'(ptr_inc(32'(first_q), OUT_BUFFER_LENGTH));
    last_qq_inc_s = PTR_W'(ptr_inc(32'(last_qq), OUT_BUFFER_LENGTH));
    wr_s          = clk_gate_i & out_valid_i & (last_qq_inc_s != first_q);
    drop_s        = clk_gate_i & out_valid_i & (last_qq_inc_s == first_q);
    eop_s         = clk_gate_i & out_ready_i;
    pop_s         = (first_q != last_q) & app_out_ready_i;
    spec_end_s    = wr_s ? last_qq_inc_s : last_qq;
    first_d_s     = pop_s ? first_inc_s : first_q;
    last_d_s      = (eop_s & ~out_err_i) ? spec_end_s : last_q;
    last_qq_d_s   = (eop_s & out_err_i) ? last_q : spec_end_s;
    ovf_d_s       = eop_s ? 1'b0 : (ovf_q | drop_s);
    used_s        = ptr_dist(32'(last_d_s), 32'(first_d_s), OUT_BUFFER_LENGTH);
    full_d_s      = ((32'(OUT_BUFFER_LENGTH) - 32'd1 - used_s) < 32'(OUT_MAXPACKETSIZE));
  end

  // Pointer, overflow, storage and full-flag registers.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      first_q    <= '0;
      last_q     <= '0;
      last_qq    <= '0;
      ovf_q      <= 1'b0;
      out_full_o <= 1'b0;
      for (int i = 0; i < OUT_BUFFER_LENGTH; i++) begin
        storage_q[i] <= 8'd0;
      end
    end else begin
      first_q <= first_d_s;
      last_q  <= last_d_s;
      last_qq <= last_qq_d_s;
      ovf_q   <= ovf_d_s;
      if (wr_s) begin
        storage_q[last_qq] <= out_data_i;
      end
      if (clk_gate_i) begin
        out_full_o <= full_d_s;
      end
    end
  end

  assign app_out_data_o  = storage_q[first_q];
  assign app_out_valid_o = (first_q != last_q);
  assign out_empty_o     = (first_q == last_q);

endmodule

// File: tb/tb_out_fifo_sc.sv
// Self-checking bench for out_fifo_sc: vector table, directed corner sequences,
// and randomized traffic against a queue-based packet model.
module tb_out_fifo_sc;

  localparam int MPS = 8;
  localparam int LEN = 16;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       gate = 1'b0;
  logic [7:0] data = 8'd0;
  logic       valid = 1'b0;
  logic       ready = 1'b0;
  logic       err = 1'b0;
  logic       full;
  logic       empty;
  logic [7:0] app_data;
  logic       app_valid;
  logic       app_ready = 1'b0;

  int errors = 0;
  int checks = 0;

  out_fifo_sc #(.OUT_MAXPACKETSIZE(MPS), .OUT_BUFFER_LENGTH(LEN)) dut (
    .clk_i(clk), .rstn_i(rstn), .clk_gate_i(gate), .out_data_i(data),
    .out_valid_i(valid), .out_ready_i(ready), .out_err_i(err),
    .out_full_o(full), .out_empty_o(empty), .app_out_data_o(app_data),
    .app_out_valid_o(app_valid), .app_out_ready_i(app_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       g;
    logic       v;
    logic [7:0] d;
    logic       r;
    logic       e;
    logic       ar;
    logic       x_valid;
    logic [7:0] x_data;
    logic       x_empty;
    logic       x_full;
  } vec_t;

  vec_t vecs [11];

  byte unsigned cq[$];
  byte unsigned sq[$];
  logic         m_full;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; gate = 1'b0; valid = 1'b0; ready = 1'b0; err = 1'b0; app_ready = 1'b0;
    cyc();
    rstn = 1'b1;
  endtask

  // One gated SIE period: strobe cycle followed by three ungated cycles.
  task automatic gcyc(input logic v, input logic [7:0] d, input logic r, input logic e);
    gate = 1'b1; valid = v; data = d; ready = r; err = e;
    cyc();
    gate = 1'b0; valid = 1'b0; ready = 1'b0; err = 1'b0;
    repeat (3) cyc();
  endtask

  task automatic pop_expect(input string name, input logic [7:0] exp);
    chk({name, "_valid"}, int'(app_valid), 1);
    chk({name, "_data"}, int'(app_data), int'(exp));
    app_ready = 1'b1;
    cyc();
    app_ready = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h33, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 8'h7E, 1'b1, 1'b0, 1'b0, 1'b1, 8'h7E, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 8'h7E, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};

    // Reset state
    do_reset();
    chk("rst_valid", int'(app_valid), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_data", int'(app_data), 0);

    // Vector table: basic commit/read and same-cycle byte + end-of-packet
    for (int i = 0; i < 11; i++) begin
      gate = vecs[i].g; valid = vecs[i].v; data = vecs[i].d;
      ready = vecs[i].r; err = vecs[i].e; app_ready = vecs[i].ar;
      cyc();
      chk($sformatf("vec%0d_valid", i), int'(app_valid), int'(vecs[i].x_valid));
      chk($sformatf("vec%0d_empty", i), int'(empty), int'(vecs[i].x_empty));
      chk($sformatf("vec%0d_full", i), int'(full), int'(vecs[i].x_full));
      if (vecs[i].x_valid) chk($sformatf("vec%0d_data", i), int'(app_data), int'(vecs[i].x_data));
    end
    gate = 1'b0; valid = 1'b0; ready = 1'b0; err = 1'b0; app_ready = 1'b0;

    // Rollback hides the packet; the next packet alone is delivered
    do_reset();
    for (int i = 0; i < 5; i++) begin
      gcyc(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
      chk("rb_spec_valid", int'(app_valid), 0);
    end
    gcyc(1'b0, 8'h00, 1'b1, 1'b1);
    chk("rb_after_valid", int'(app_valid), 0);
    chk("rb_after_empty", int'(empty), 1);
    gcyc(1'b1, 8'h55, 1'b0, 1'b0);
    gcyc(1'b0, 8'h00, 1'b1, 1'b0);
    pop_expect("rb_next", 8'h55);
    chk("rb_next_empty", int'(empty), 1);

    // Full threshold: 8 committed of 15 usable, then one pop frees it at the next gate
    do_reset();
    for (int i = 0; i < 8; i++) gcyc(1'b1, 8'(i), 1'b0, 1'b0);
    chk("full_spec_only", int'(full), 0);
    gcyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("full_set", int'(full), 1);
    pop_expect("full_pop", 8'h00);
    chk("full_held_until_gate", int'(full), 1);
    gcyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("full_cleared", int'(full), 0);

    // Overflow: 17 bytes into an empty buffer keeps the first 15
    do_reset();
    for (int i = 0; i < 17; i++) gcyc(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
    chk("ovf_set", int'(dut.ovf_q), 1);
    gcyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("ovf_cleared", int'(dut.ovf_q), 0);
    chk("ovf_full", int'(full), 1);
    for (int i = 0; i < 15; i++) pop_expect($sformatf("ovf_rd%0d", i), 8'h40 + 8'(i));
    chk("ovf_drained_empty", int'(empty), 1);

    // Reset mid-packet discards committed and speculative data
    do_reset();
    for (int i = 0; i < 4; i++) gcyc(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
    gcyc(1'b0, 8'h00, 1'b1, 1'b0);
    gcyc(1'b1, 8'hD0, 1'b0, 1'b0);
    gcyc(1'b1, 8'hD1, 1'b0, 1'b0);
    chk("mid_pre_valid", int'(app_valid), 1);
    do_reset();
    chk("mid_valid", int'(app_valid), 0);
    chk("mid_empty", int'(empty), 1);
    chk("mid_full", int'(full), 0);
    chk("mid_data_cleared", int'(app_data), 0);
    gcyc(1'b1, 8'h99, 1'b0, 1'b0);
    gcyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("mid_ptr_first", int'(dut.first_q), 0);
    pop_expect("mid_fresh", 8'h99);

    // Randomized traffic against a packet-level model
    do_reset();
    cq.delete(); sq.delete(); m_full = 1'b0;
    for (int c = 0; c < 6000; c++) begin
      logic pop_m;
      gate  = (c % 4 == 0);
      valid = gate & ($urandom_range(0, 3) != 0);
      data  = 8'($urandom);
      ready = gate & ($urandom_range(0, 11) == 0);
      err   = ($urandom_range(0, 3) == 0);
      app_ready = ((c / 300) % 2 == 0) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 1) == 1);
      pop_m = (cq.size() != 0) && app_ready;
      if (gate && valid && (cq.size() + sq.size() < LEN - 1)) sq.push_back(data);
      if (gate && ready) begin
        if (!err) foreach (sq[k]) cq.push_back(sq[k]);
        sq.delete();
      end
      if (pop_m) void'(cq.pop_front());
      if (gate) m_full = ((LEN - 1 - cq.size()) < MPS);
      cyc();
      chk("rnd_valid", int'(app_valid), int'(cq.size() != 0));
      chk("rnd_empty", int'(empty), int'(cq.size() == 0));
      chk("rnd_full", int'(full), int'(m_full));
      if (cq.size() != 0) chk("rnd_data", int'(app_data), int'(cq[0]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
